// File: rtl/iic_pkg.sv
// Shared IIC definitions: responder state encoding, bus constants, default
// device address and the word-address increment helper.
package iic_pkg;

    // One-hot responder states
    typedef enum logic [8:0] {
        S_IDLE      = 9'b000000001,
        S_DEV       = 9'b000000010,
        S_ADDR_H    = 9'b000000100,
        S_ADDR_L    = 9'b000001000,
        S_WR_DATA   = 9'b000010000,
        S_RD_DATA   = 9'b000100000,
        S_RD_ACK    = 9'b001000000,
        S_WAIT_STOP = 9'b010000000,
        S_ACK       = 9'b100000000
    } state_t;

    localparam logic       RW_READ      = 1'b1;
    localparam logic       ACK          = 1'b0;
    localparam logic       NACK         = 1'b1;
    localparam logic [6:0] DEF_DEV_ADDR = 7'b1010000;

    // Word-address increment, wrapping at the configured address width
    function automatic logic [15:0] addr_inc(input logic [15:0] a, input int nbytes);
        return (nbytes == 1) ? {8'h00, a[7:0] + 8'd1} : a + 16'd1;
    endfunction

endpackage

// File: rtl/iic_line_cond.sv
// SCL/SDA conditioning: 2-FF synchroniser, optional 3-sample stable filter
// (IIC_GLITCH_FILTER_EN), history FF and edge / START / STOP detection.
module iic_line_cond (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f;
    logic       scl_d, sda_d;

    // Two-stage synchroniser; resets to the idle bus level
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef IIC_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;

    // Filtered level only follows three consecutive equal samples
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            if (scl_hist == 3'b111)      scl_f <= 1'b1;
            else if (scl_hist == 3'b000) scl_f <= 1'b0;
            if (sda_hist == 3'b111)      sda_f <= 1'b1;
            else if (sda_hist == 3'b000) sda_f <= 1'b0;
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    // History stage for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign sda_s     = sda_f;

endmodule

// File: rtl/iic_slave_eeprom.sv
// 24Cxx-style EEPROM emulating IIC responder with a synchronous memory port.
// Optional input glitch filter: define IIC_GLITCH_FILTER_EN.
// HOLD_CYC must be >= 3 so read data is loaded before bit 7 is driven.
module iic_slave_eeprom
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
    parameter int         ADDR_BYTES = 2,
    parameter int         HOLD_CYC   = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        xfer_done
);

    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYC);
    localparam state_t     FIRST_ADDR = (ADDR_BYTES == 2) ? S_ADDR_H : S_ADDR_L;

    logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
    logic [7:0] hold_cnt;
    logic       drive_pt;
    state_t     state, ack_ret;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic       sda_oe;
    logic       re_d;

    // Open drain: only ever pull low
    assign sda = sda_oe ? 1'b0 : 1'bz;

    iic_line_cond u_line_cond (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    // Hold timer: drive_pt fires HOLD_CYC cycles after each SCL fall
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                hold_cnt <= '0;
        else if (start_det || stop_det) hold_cnt <= '0;
        else if (scl_fall)             hold_cnt <= HOLD_INIT;
        else if (hold_cnt != 8'd0)     hold_cnt <= hold_cnt - 8'd1;
    end

    assign drive_pt = (hold_cnt == 8'd1);

    // Protocol FSM with registered SDA enable and memory strobes
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            ack_ret   <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            sda_oe    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            re_d      <= 1'b0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            xfer_done <= 1'b0;
            re_d      <= mem_re;

            // Post-write address advance, and read data capture
            if (mem_we) mem_addr <= addr_inc(mem_addr, ADDR_BYTES);
            if (re_d)   shreg    <= mem_rdata;

            // SDA only changes at the hold point after an SCL fall
            if (drive_pt) begin
                case (state)
                    S_ACK:     sda_oe <= 1'b1;
                    S_RD_DATA: sda_oe <= ~shreg[7];
                    default:   sda_oe <= 1'b0;
                endcase
            end

            if (stop_det) begin
                state     <= S_IDLE;
                sda_oe    <= 1'b0;
                bit_cnt   <= '0;
                xfer_done <= busy;
                busy      <= 1'b0;
            end else if (start_det) begin
                state   <= S_DEV;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                busy    <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    S_DEV, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
                        shreg   <= {shreg[6:0], sda_s};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    S_RD_DATA: bit_cnt <= bit_cnt + 4'd1;
                    S_RD_ACK: begin
                        if (sda_s == ACK) begin
                            mem_addr <= addr_inc(mem_addr, ADDR_BYTES);
                            mem_re   <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= S_RD_DATA;
                        end else begin
                            state <= S_WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    S_DEV: if (bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                        if (shreg[7:1] == DEV_ADDR) begin
                            busy    <= 1'b1;
                            state   <= S_ACK;
                            ack_ret <= (shreg[0] == RW_READ) ? S_RD_DATA : FIRST_ADDR;
                        end else begin
                            state <= S_WAIT_STOP;
                        end
                    end
                    S_ADDR_H: if (bit_cnt == 4'd8) begin
                        mem_addr[15:8] <= shreg;
                        state          <= S_ACK;
                        ack_ret        <= S_ADDR_L;
                    end
                    S_ADDR_L: if (bit_cnt == 4'd8) begin
                        mem_addr[7:0] <= shreg;
                        if (ADDR_BYTES != 2) mem_addr[15:8] <= 8'h00;
                        state   <= S_ACK;
                        ack_ret <= S_WR_DATA;
                    end
                    S_WR_DATA: if (bit_cnt == 4'd8) begin
                        mem_wdata <= shreg;
                        mem_we    <= 1'b1;
                        state     <= S_ACK;
                        ack_ret   <= S_WR_DATA;
                    end
                    // Fall that ends our ACK bit
                    S_ACK: begin
                        state   <= ack_ret;
                        bit_cnt <= '0;
                        if (ack_ret == S_RD_DATA) mem_re <= 1'b1;
                    end
                    S_RD_DATA: begin
                        if (bit_cnt == 4'd8)       state <= S_RD_ACK;
                        else if (bit_cnt != 4'd0)  shreg <= {shreg[6:0], 1'b0};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_eeprom.sv
// Directed bench: bit-banged IIC master, memory responder and strobe monitor.
module tb_iic_slave_eeprom;

    localparam int Q = 16;  // sys_clk cycles per quarter SCL bit

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        m_oe = 1'b0;
    wire         sda;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_we, mem_re, busy, xfer_done;

    int total = 0;
    int bad = 0;
    int we_cnt = 0, re_cnt = 0, xfer_cnt = 0, both_cnt = 0;
    logic [15:0] we_addr = '0;
    logic [7:0]  we_data = '0;
    logic [15:0] re_addr [$];

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 sys_clk = ~sys_clk;

    iic_slave_eeprom #(.DEV_ADDR(7'h50), .ADDR_BYTES(2), .HOLD_CYC(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .scl       (scl),
        .sda       (sda),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h0010: return 8'h3C;
            16'hFFFE: return 8'h11;
            16'hFFFF: return 8'h22;
            16'h0000: return 8'h33;
            default:  return 8'hEE;
        endcase
    endfunction

    // Synchronous read memory: data valid the cycle after mem_re
    always @(posedge sys_clk) if (mem_re) mem_rdata <= rom(mem_addr);

    // Strobe monitor
    always @(negedge sys_clk) begin
        if (mem_we) begin we_cnt++; we_addr = mem_addr; we_data = mem_wdata; end
        if (mem_re) begin re_cnt++; re_addr.push_back(mem_addr); end
        if (xfer_done) xfer_cnt++;
        if (mem_we && mem_re) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge sys_clk);
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        wait_q(); m_oe = ~b;
        wait_q(); scl = 1'b1;
        wait_q(); r = sda;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q(); m_oe = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); m_oe = 1'b1;
        wait_q(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q(); m_oe = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q(); m_oe = 1'b0;
        wait_q();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
        i2c_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d, output logic rel);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            d[i] = r;
        end
        i2c_bit(~mack, rel);
    endtask

    initial begin
        logic       a0, a1, a2, a3, rel, r;
        logic [7:0] d;

        // Reset state
        repeat (5) @(negedge sys_clk);
        chk("rst_sda", sda, 1'b1);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_re", mem_re, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", xfer_done, 1'b0);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        // Write 0xA5 to 0x1234
        i2c_start();
        wr_byte(8'hA0, a0);
        chk("wr_busy", busy, 1'b1);
        wr_byte(8'h12, a1);
        wr_byte(8'h34, a2);
        wr_byte(8'hA5, a3);
        i2c_stop();
        chk("wr_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("wr_we_cnt", we_cnt, 1);
        chk("wr_we_addr", we_addr, 16'h1234);
        chk("wr_we_data", we_data, 8'hA5);
        chk("wr_addr_inc", mem_addr, 16'h1235);
        chk("wr_xfer", xfer_cnt, 1);
        chk("wr_busy_end", busy, 1'b0);

        // Random read of 0x0010
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h00, a1);
        wr_byte(8'h10, a2);
        i2c_start();
        chk("rs_busy_drop", busy, 1'b0);
        wr_byte(8'hA1, a3);
        chk("rr_acks", {a0, a1, a2, a3}, 4'b0000);
        rd_byte(1'b0, d, rel);
        i2c_stop();
        chk("rr_data", d, 8'h3C);
        chk("rr_release", rel, 1'b1);
        chk("rr_re_cnt", re_cnt, 1);
        chk("rr_re_addr", re_addr[0], 16'h0010);
        chk("rr_we_cnt", we_cnt, 1);
        chk("rr_addr", mem_addr, 16'h0010);
        chk("rr_xfer", xfer_cnt, 2);

        // Sequential read from 0xFFFE with address wrap
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'hFF, a1);
        wr_byte(8'hFE, a2);
        i2c_start();
        wr_byte(8'hA1, a3);
        chk("sr_acks", {a0, a1, a2, a3}, 4'b0000);
        rd_byte(1'b1, d, rel);
        chk("sr_d0", d, 8'h11);
        rd_byte(1'b1, d, rel);
        chk("sr_d1", d, 8'h22);
        rd_byte(1'b0, d, rel);
        chk("sr_d2", d, 8'h33);
        chk("sr_release", rel, 1'b1);
        i2c_stop();
        chk("sr_re_cnt", re_cnt, 4);
        chk("sr_re_a0", re_addr[1], 16'hFFFE);
        chk("sr_re_a1", re_addr[2], 16'hFFFF);
        chk("sr_re_a2", re_addr[3], 16'h0000);
        chk("sr_addr", mem_addr, 16'h0000);

        // Wrong device address 0x51
        i2c_start();
        wr_byte(8'hA2, a0);
        chk("wa_nack", a0, 1'b1);
        chk("wa_busy", busy, 1'b0);
        wr_byte(8'h00, a1);
        chk("wa_nack2", a1, 1'b1);
        chk("wa_busy2", busy, 1'b0);
        i2c_stop();
        chk("wa_we_cnt", we_cnt, 1);
        chk("wa_re_cnt", re_cnt, 4);
        chk("wa_xfer", xfer_cnt, 3);

        // STOP after 4 data bits, then a normal write
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h12, a1);
        wr_byte(8'h34, a2);
        for (int i = 0; i < 4; i++) i2c_bit(1'b1, r);
        i2c_stop();
        chk("ps_acks", {a0, a1, a2}, 3'b000);
        chk("ps_we_cnt", we_cnt, 1);
        chk("ps_addr", mem_addr, 16'h1234);
        chk("ps_xfer", xfer_cnt, 4);
        i2c_start();
        wr_byte(8'hA0, a0);
        wr_byte(8'h12, a1);
        wr_byte(8'h34, a2);
        wr_byte(8'h5A, a3);
        i2c_stop();
        chk("ps2_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("ps2_we_cnt", we_cnt, 2);
        chk("ps2_we_addr", we_addr, 16'h1234);
        chk("ps2_we_data", we_data, 8'h5A);
        chk("ps2_xfer", xfer_cnt, 5);

        // Async reset while ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(i == 7 || i == 5, r);
        wait_q(); m_oe = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q();
        chk("ar_ack_low", sda, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        chk("ar_sda", sda, 1'b1);
        chk("ar_busy", busy, 1'b0);
        chk("ar_addr", mem_addr, 16'h0000);
        chk("ar_wdata", mem_wdata, 8'h00);
        chk("ar_strobes", {mem_we, mem_re, xfer_done}, 3'b000);
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("ar_we_cnt", we_cnt, 2);
        chk("ar_re_cnt", re_cnt, 4);
        chk("ar_xfer", xfer_cnt, 5);
        chk("both_strobes", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
